// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences the shared ALU, the unified memory port
// and the register file, and counts retired instructions.
module multicycle_control #(
    parameter logic TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_alu_func,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_iord,
    output logic        o_ir_we,
    output logic        o_pc_we,
    output logic        o_reg_we,
    output logic [1:0]  o_pc_src,
    output logic        o_reg_dst,
    output logic        o_mem_to_reg,
    output logic        o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [2:0]  o_alu_ctrl,
    output logic        o_illegal,
    output logic [31:0] o_retired,
    output logic [3:0]  o_state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11,
        StIllegal = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;

    state_e      r_state;
    state_e      w_next;
    logic        w_funct_ok;
    logic [2:0]  w_funct_ctrl;
    logic        w_retire;

    always_comb begin
        w_funct_ok   = 1'b1;
        w_funct_ctrl = AluAdd;
        unique case (i_alu_func)
            6'b100000: w_funct_ctrl = AluAdd;
            6'b100010: w_funct_ctrl = AluSub;
            6'b100100: w_funct_ctrl = 3'b000;
            6'b100101: w_funct_ctrl = 3'b001;
            6'b101010: w_funct_ctrl = 3'b111;
            default:   w_funct_ok   = 1'b0;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_iord       = 1'b0;
        o_ir_we      = 1'b0;
        o_pc_we      = 1'b0;
        o_reg_we     = 1'b0;
        o_pc_src     = 2'b00;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'b00;
        o_alu_ctrl   = 3'b000;
        o_illegal    = 1'b0;
        unique case (r_state)
            StFetch: begin
                o_mem_req   = 1'b1;
                o_alu_src_b = 2'b01;
                o_alu_ctrl  = AluAdd;
                if (i_mem_ready) begin
                    o_ir_we = 1'b1;
                    o_pc_we = 1'b1;
                    w_next  = StDecode;
                end
            end
            StDecode: begin
                o_alu_src_b = 2'b11;
                o_alu_ctrl  = AluAdd;
                case (i_op)
                    OpLw, OpSw: w_next = StMemAdr;
                    OpRtype:    w_next = w_funct_ok ? StExec : StIllegal;
                    OpBeq:      w_next = StBranch;
                    OpAddi:     w_next = StAddiEx;
                    OpJ:        w_next = StJump;
                    default:    w_next = StIllegal;
                endcase
            end
            StMemAdr: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                o_alu_ctrl  = AluAdd;
                w_next      = (i_op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
                if (i_mem_ready) w_next = StMemWb;
            end
            StMemWb: begin
                o_reg_we     = 1'b1;
                o_mem_to_reg = 1'b1;
                w_next       = StFetch;
            end
            StMemWr: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                o_iord    = 1'b1;
                if (i_mem_ready) w_next = StFetch;
            end
            StExec: begin
                o_alu_src_a = 1'b1;
                o_alu_ctrl  = w_funct_ctrl;
                w_next      = StAluWb;
            end
            StAluWb: begin
                o_reg_we  = 1'b1;
                o_reg_dst = 1'b1;
                w_next    = StFetch;
            end
            StBranch: begin
                o_alu_src_a = 1'b1;
                o_alu_ctrl  = AluSub;
                o_pc_src    = 2'b01;
                o_pc_we     = i_zero;
                w_next      = StFetch;
            end
            StAddiEx: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                o_alu_ctrl  = AluAdd;
                w_next      = StAddiWb;
            end
            StAddiWb: begin
                o_reg_we = 1'b1;
                w_next   = StFetch;
            end
            StJump: begin
                o_pc_src = 2'b10;
                o_pc_we  = 1'b1;
                w_next   = StFetch;
            end
            StIllegal: begin
                o_illegal = 1'b1;
                w_next    = TRAP_ON_ILLEGAL ? StIllegal : StFetch;
            end
            default: w_next = StFetch;
        endcase
        // Reset abandons any in-flight transfer or writeback on the reset cycle itself.
        if (i_reset) begin
            o_mem_req = 1'b0;
            o_mem_we  = 1'b0;
            o_ir_we   = 1'b0;
            o_pc_we   = 1'b0;
            o_reg_we  = 1'b0;
        end
    end

    assign w_retire = (w_next == StFetch) && (r_state != StFetch) && (r_state != StIllegal);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StFetch;
            o_retired <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_retire) o_retired <= o_retired + 32'd1;
        end
    end

    assign o_state = r_state;

endmodule
